// File: rtl/pim_pkg.sv
// ============================================================================
// Module  : pim_pkg
// Brief   : Shared constants, window address and result-buffer FSM state codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pim_pkg;

  localparam int          C_NUM_COL         = 32;
  localparam int          C_RES_W           = 16;
  localparam int          C_BUS_W           = 32;
  localparam logic [31:0] C_RESULT_WIN_ADDR = 32'h4000_0020;

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_FULL  = 2'd1;
  localparam logic [1:0] C_ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_FULL  = C_ST_FULL,
    ST_DRAIN = C_ST_DRAIN
  } rb_state_t;

endpackage

`default_nettype wire

// File: rtl/pim_result_relu.sv
// ============================================================================
// Module  : pim_result_relu
// Brief   : Per-column signed clamp (negative -> 0); built only when
//           PIM_RESULT_RELU_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef PIM_RESULT_RELU_EN
module pim_result_relu #(
  parameter int NUM_COL = 32,
  parameter int RES_W   = 16
) (
  input  logic [NUM_COL*RES_W-1:0] i_cols,
  output logic [NUM_COL*RES_W-1:0] o_cols
);

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    logic [RES_W-1:0] w_col;
    assign w_col = i_cols[c*RES_W +: RES_W];
    assign o_cols[c*RES_W +: RES_W] = w_col[RES_W-1] ? '0 : w_col;
  end

endmodule
`endif

`default_nettype wire

// File: rtl/pim_result_buffer.sv
// ============================================================================
// Module  : pim_result_buffer
// Brief   : Captures a macro result frame and serialises it as bus words.
//           Optional input clamp enabled by defining PIM_RESULT_RELU_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pim_result_buffer
  import pim_pkg::*;
#(
  parameter int NUM_COL = C_NUM_COL,
  parameter int RES_W   = C_RES_W,
  parameter int BUS_W   = C_BUS_W
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_result_in_en,
  input  logic [NUM_COL*RES_W-1:0]                  i_pim_result,
  input  logic                                      i_rd_en,
  input  logic                                      i_clear,
  output logic [BUS_W-1:0]                          o_rdata,
  output logic                                      o_rvalid,
  output logic                                      o_valid,
  output logic                                      o_overrun,
  output logic [$clog2((NUM_COL*RES_W)/BUS_W)-1:0]  o_rd_ptr
);

  localparam int FRAME_W   = NUM_COL * RES_W;
  localparam int NUM_WORDS = FRAME_W / BUS_W;
  localparam int PTR_W     = $clog2(NUM_WORDS);
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(NUM_WORDS - 1);

  rb_state_t          r_state;
  logic [FRAME_W-1:0] r_frame;
  logic [FRAME_W-1:0] w_frame_in;
  logic [BUS_W-1:0]   w_word;
  logic               w_active;
  logic               w_last;

`ifdef PIM_RESULT_RELU_EN
  pim_result_relu #(
    .NUM_COL (NUM_COL),
    .RES_W   (RES_W)
  ) u_relu (
    .i_cols (i_pim_result),
    .o_cols (w_frame_in)
  );
`else
  assign w_frame_in = i_pim_result;
`endif

  // A clear in the same cycle makes any read behave as an IDLE read.
  assign w_active = (r_state != ST_IDLE) && !i_clear;
  assign w_last   = (o_rd_ptr == C_LAST_PTR);
  assign w_word   = r_frame[int'(o_rd_ptr)*BUS_W +: BUS_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      o_rdata   <= '0;
      o_rvalid  <= 1'b0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      o_rd_ptr  <= '0;
    end else begin
      o_rvalid <= i_rd_en;
      if (i_rd_en) begin
        o_rdata <= w_active ? w_word : '0;
      end

      if (i_clear) begin
        r_state   <= ST_IDLE;
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
        o_rd_ptr  <= '0;
      end else if (i_rd_en && w_active) begin
        if (w_last) begin
          r_state  <= ST_IDLE;
          o_valid  <= 1'b0;
          o_rd_ptr <= '0;
        end else begin
          r_state  <= ST_DRAIN;
          o_rd_ptr <= o_rd_ptr + 1'b1;
        end
      end

      // Capture overrides the read/clear updates; reading the last word is a clean refill.
      if (i_result_in_en) begin
        r_frame  <= w_frame_in;
        r_state  <= ST_FULL;
        o_valid  <= 1'b1;
        o_rd_ptr <= '0;
        if (w_active && !(i_rd_en && w_last)) begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pim_result_buffer.sv
// ============================================================================
// Module  : tb_pim_result_buffer
// Brief   : Directed table-driven bench for pim_result_buffer (honours
//           PIM_RESULT_RELU_EN for the clamp expectation).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pim_result_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cap;
  logic [511:0] pim;
  logic         rd;
  logic         clr;
  logic [31:0]  rdata;
  logic         rvalid;
  logic         valid;
  logic         overrun;
  logic [3:0]   rd_ptr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pim_result_buffer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_result_in_en (cap),
    .i_pim_result   (pim),
    .i_rd_en        (rd),
    .i_clear        (clr),
    .o_rdata        (rdata),
    .o_rvalid       (rvalid),
    .o_valid        (valid),
    .o_overrun      (overrun),
    .o_rd_ptr       (rd_ptr)
  );

  typedef struct {
    bit          cap;
    bit          rd;
    bit          clr;
    int          sel;
    bit          e_rvalid;
    logic [31:0] e_rdata;
    bit          e_valid;
    bit          e_ovr;
    int          e_ptr;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // sel 0: col c = c+1; sel 1: col c = 0x100+c; sel 2: col0=-3, col1=7, rest 0
  function automatic logic [511:0] mk_frame(int sel);
    logic [511:0] f;
    f = '0;
    for (int c = 0; c < 32; c++) begin
      if (sel == 0) f[c*16 +: 16] = 16'(c + 1);
      if (sel == 1) f[c*16 +: 16] = 16'(256 + c);
    end
    if (sel == 2) begin
      f[15:0]  = 16'hFFFD;
      f[31:16] = 16'h0007;
    end
    return f;
  endfunction

  function automatic logic [31:0] ramp_w(int k);
    return {16'(2*k + 2), 16'(2*k + 1)};
  endfunction

  function automatic logic [31:0] b_w(int k);
    return {16'(256 + 2*k + 1), 16'(256 + 2*k)};
  endfunction

  function automatic void add(bit c, bit r, bit cl, int sel, bit erv, logic [31:0] erd,
                              bit ev, bit eo, int ep, string nm);
    vec_t v;
    v.cap = c; v.rd = r; v.clr = cl; v.sel = sel;
    v.e_rvalid = erv; v.e_rdata = erd; v.e_valid = ev; v.e_ovr = eo; v.e_ptr = ep;
    v.name = nm;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_outs(string nm, bit erv, logic [31:0] erd, bit ev, bit eo, int ep);
    chk({nm, ".rvalid"}, {31'd0, rvalid}, {31'd0, erv});
    if (erv) chk({nm, ".rdata"}, rdata, erd);
    chk({nm, ".valid"}, {31'd0, valid}, {31'd0, ev});
    chk({nm, ".overrun"}, {31'd0, overrun}, {31'd0, eo});
    chk({nm, ".ptr"}, {28'd0, rd_ptr}, 32'(ep));
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    cap = v.cap; rd = v.rd; clr = v.clr; pim = mk_frame(v.sel);
    @(posedge clk);
    #1;
    check_outs(v.name, v.e_rvalid, v.e_rdata, v.e_valid, v.e_ovr, v.e_ptr);
    cap = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  logic [31:0] neg_w0;

  initial begin
`ifdef PIM_RESULT_RELU_EN
    neg_w0 = 32'h0007_0000;
`else
    neg_w0 = 32'h0007_FFFD;
`endif
    // Read in IDLE, then full ramp frame drain
    add(0, 1, 0, 0, 1, 32'h0, 0, 0, 0, "idle_rd");
    add(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, "idle_nop");
    add(1, 0, 0, 0, 0, 32'h0, 1, 0, 0, "cap_ramp");
    add(0, 1, 0, 0, 1, 32'h0002_0001, 1, 0, 1, "ramp_w0");
    for (int k = 1; k < 15; k++) add(0, 1, 0, 0, 1, ramp_w(k), 1, 0, k + 1, "ramp_wk");
    add(0, 1, 0, 0, 1, 32'h0020_001F, 0, 0, 0, "ramp_w15");
    add(0, 1, 0, 0, 1, 32'h0, 0, 0, 0, "rd_after_last");
    // Overrun: capture after 5 reads
    add(1, 0, 0, 1, 0, 32'h0, 1, 0, 0, "cap_b");
    add(0, 1, 0, 0, 1, 32'h0101_0100, 1, 0, 1, "b_w0");
    for (int k = 1; k < 5; k++) add(0, 1, 0, 0, 1, b_w(k), 1, 0, k + 1, "b_wk");
    add(1, 0, 0, 0, 0, 32'h0, 1, 1, 0, "ovr_cap");
    add(0, 1, 0, 0, 1, 32'h0002_0001, 1, 1, 1, "ovr_new_w0");
    add(0, 0, 1, 0, 0, 32'h0, 0, 0, 0, "clear");
    // Capture together with the last read: clean refill
    add(1, 0, 0, 1, 0, 32'h0, 1, 0, 0, "cap_b2");
    for (int k = 0; k < 15; k++) add(0, 1, 0, 0, 1, b_w(k), 1, 0, k + 1, "b2_wk");
    add(1, 1, 0, 0, 1, 32'h011F_011E, 1, 0, 0, "cap_on_last");
    add(0, 1, 0, 0, 1, 32'h0002_0001, 1, 0, 1, "refill_w0");
    add(1, 1, 0, 1, 1, 32'h0004_0003, 1, 1, 0, "cap_on_mid_rd");
    add(0, 1, 0, 0, 1, 32'h0101_0100, 1, 1, 1, "mid_new_w0");
    add(1, 0, 1, 2, 0, 32'h0, 1, 0, 0, "clr_and_cap");
    add(0, 1, 0, 0, 1, neg_w0, 1, 0, 1, "neg_w0");

    rst = 1'b1; cap = 1'b0; rd = 1'b0; clr = 1'b0; pim = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 32'h0, 0, 0, 0);
    chk("reset.rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset mid-drain with a read pending
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; cap = 1'b1; pim = mk_frame(0);
    @(negedge clk); cap = 1'b0; rd = 1'b1;
    repeat (3) @(negedge clk);
    rd = 1'b0;
    chk("pre_rst.ptr", {28'd0, rd_ptr}, 32'd3);
    rst = 1'b1; rd = 1'b1;
    @(posedge clk);
    #1;
    check_outs("mid_rst", 0, 32'h0, 0, 0, 0);
    chk("mid_rst.rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; rd = 1'b0;
    @(posedge clk);
    #1;
    check_outs("post_rst", 0, 32'h0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
